uart_reg_rx: RTL and testbench
==============================

Name: uart_reg_rx

Overview:
Parametrised successor to the tt05 serial register receiver, using the same two-byte register-write protocol.
- Byte 1 (msb=0) carries D[6:0]; byte 2 (msb=1) carries D7 in bit 0 and the address in bits 6:1.
- Adds: configurable oversample ratio and address width, start-bit validation, framing/sequence/overrun detection, a valid/ack output handshake and a saturating error counter.
- Sits between the pad-level rx input and the register file.

Parameters:
BAUD_DIV, 6, uart_clk ticks per bit (legal 4..15).
ADDR_W, 4, address bits delivered (legal 1..6); taken from byte-2 bits [ADDR_W:1].
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
uart_clk  in  1  clock-enable tick at BAUD_DIV x baud; all receive logic advances only on ticks
rx  in  1  asynchronous serial input, idle high
uart_addr  out  ADDR_W  register address of the completed word
uart_data  out  8  register data of the completed word
uart_valid  out  1  word available; held until acknowledged
uart_ack  in  1  consumer accepts the word when uart_valid && uart_ack
frame_err  out  1  one-clk pulse: stop bit sampled low
seq_err  out  1  one-clk pulse: byte 2 received with no pending byte 1
overrun  out  1  one-clk pulse: word completed while uart_valid held and not acked
parity_err  out  1  one-clk pulse: parity mismatch (tied 0 without the option)
err_count  out  ERR_CNT_W  saturating count of all error pulses

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0.
  - rx 2-flop synchroniser loads 1; tick counter loads 0; FSM enters IDLE.
  - Pending-byte-1 flag and armed flag clear.
  - Reset mid-frame abandons the frame.
- Start detection is allowed only once armed. Armed sets after the synchronised rx is seen high on one tick.
- FSM (advances on uart_clk ticks only):
  - IDLE:
    - Synchronised rx 1->0 while armed: clear tick count, go to START.
  - START:
    - At tick count BAUD_DIV/2 (integer divide), rx sampled high: false start, back to IDLE.
    - Sampled low: restart the count, go to DATA.
  - DATA:
    - Sample every BAUD_DIV ticks, 8 bits, LSB first.
    - Then go to PARITY if the option is compiled in, else STOP.
  - STOP:
    - Sample = 1: byte accepted, go to IDLE.
    - Sample = 0: frame_err pulse, byte discarded, go to BREAK.
  - BREAK:
    - Wait for synchronised rx = 1, then IDLE.
- Byte assembly (on an accepted byte b):
  - b[7]=0: hold <= b[6:0]; pending set. A second consecutive byte 1 overwrites hold.
  - b[7]=1 with pending set: word completes with data = {b[0], hold} and addr = b[ADDR_W:1]; pending clears.
  - b[7]=1 with pending clear: seq_err pulse, byte dropped.
- Output handshake:
  - A word completing on the stop-sample clk cycle T loads uart_addr and uart_data, and asserts uart_valid at T+1.
  - uart_valid drops on the cycle after uart_valid && uart_ack.
  - uart_data and uart_addr are stable while uart_valid = 1.
- Simultaneous events:
  - Word completes in the same cycle as ack: the new word loads and uart_valid stays 1.
  - Word completes while uart_valid = 1 and no ack: overrun pulse; the old word is kept and the new one dropped.
- err_count increments by 1 per clk cycle in which any error pulse is high (one increment even if several are high), and saturates at all-ones.
- Maximum length of a pulse output is one clk cycle.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - An even-parity bit follows D7, sampled BAUD_DIV ticks after D7.
  - Mismatch gives a parity_err pulse; the byte is discarded with no assembly effect. The FSM still checks the stop bit.
  - Frame length is 11 bits.
- Undefined:
  - No parity state; parity_err is tied 0.
  - Frame length is 10 bits.

Test Plan:
1. BAUD_DIV=6, ADDR_W=4: send 0x35 then 0x8B -> uart_valid=1 at T+1, uart_data=0xB5, uart_addr=0x5. Ack -> uart_valid=0 next cycle.
2. Send 0x8B alone from reset -> seq_err one pulse, err_count=1, uart_valid stays 0. Then send 0x35, 0x8B -> word 0xB5/0x5 delivered.
3. Send 0x35, 0x8B with no ack, then 0x12, 0x81 -> overrun pulse; output holds 0xB5/0x5. Repeat with ack in the completion cycle -> output 0x92/0x0, uart_valid stays 1.
4. Send 0x35 with the stop bit forced low, hold rx low 30 ticks, then release -> frame_err once, FSM in BREAK until rx high. Next pair 0x35, 0x8B decodes correctly.
5. rx low pulse of 2 ticks in IDLE -> no byte, no errors. Assert rst_n=0 mid-DATA with rx held low, release -> no start detected until rx has been high for a tick.
6. With UART_RX_PARITY_EN: send 0x35 with an odd parity bit -> parity_err pulse, pending unchanged. Force 300 errors with ERR_CNT_W=8 -> err_count saturates at 0xFF.

Source files
------------

// File: rtl/uart_reg_rx_if.sv
// rtl/uart_reg_rx_if.sv - completed-word handshake between uart_reg_rx and the register file
interface uart_reg_rx_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] uart_addr;
   logic [7:0]        uart_data;
   logic              uart_valid;
   logic              uart_ack;

   modport master (output uart_addr, output uart_data, output uart_valid, input uart_ack);
   modport slave  (input uart_addr, input uart_data, input uart_valid, output uart_ack);
endinterface

// File: rtl/uart_reg_rx.sv
// rtl/uart_reg_rx.sv - two-byte serial register-write receiver with error reporting
// Optional even parity bit after D7 when UART_RX_PARITY_EN is defined.
module uart_reg_rx #(
   parameter int BAUD_DIV  = 6,
   parameter int ADDR_W    = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_clk,
   input  logic                 rx,
   uart_reg_rx_if.master        bus,
   output logic                 frame_err,
   output logic                 seq_err,
   output logic                 overrun,
   output logic                 parity_err,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam logic [3:0] HALF = 4'(BAUD_DIV / 2);
   localparam logic [3:0] LAST = 4'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic [2:0]        bit_idx, bit_nx;
   logic [7:0]        shreg, sh_nx;
   logic              par_bad, par_bad_nx;
   logic              rx_s1, rx_s2, rx_prev, armed;
   logic [1:0]        settle;
   logic              pending;
   logic [6:0]        hold;
   logic              byte_ok, frame_c, seq_c, ovr_c, word_done, load, any_err;
   logic              valid_q;
   logic [7:0]        data_q;
   logic [ADDR_W-1:0] addr_q;
`ifdef UART_RX_PARITY_EN
   logic              par_c;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_nx     = bit_idx;
      sh_nx      = shreg;
      par_bad_nx = par_bad;
      byte_ok    = 1'b0;
      frame_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_c      = 1'b0;
`endif
      if (uart_clk) begin
         case (state)
            S_IDLE: begin
               if (armed && rx_prev && !rx_s2) begin
                  cnt_nx   = 4'd0;
                  state_nx = S_START;
               end
            end
            S_START: begin
               if (cnt == HALF) begin
                  cnt_nx     = 4'd0;
                  bit_nx     = 3'd0;
                  par_bad_nx = 1'b0;
                  state_nx   = rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
            S_DATA: begin
               if (cnt == LAST) begin
                  cnt_nx = 4'd0;
                  sh_nx  = {rx_s2, shreg[7:1]};
                  bit_nx = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_nx = S_PARITY;
`else
                     state_nx = S_STOP;
`endif
                  end
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == LAST) begin
                  cnt_nx     = 4'd0;
                  par_c      = (^shreg) != rx_s2;
                  par_bad_nx = par_c;
                  state_nx   = S_STOP;
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == LAST) begin
                  cnt_nx = 4'd0;
                  if (rx_s2) begin
                     byte_ok  = !par_bad;
                     state_nx = S_IDLE;
                  end else begin
                     frame_c  = 1'b1;
                     state_nx = S_BREAK;
                  end
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
            S_BREAK: begin
               if (rx_s2) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign word_done = byte_ok && shreg[7] && pending;
   assign seq_c     = byte_ok && shreg[7] && !pending;
   assign ovr_c     = word_done && valid_q && !bus.uart_ack;
   assign load      = word_done && !ovr_c;
`ifdef UART_RX_PARITY_EN
   assign any_err   = frame_c | seq_c | ovr_c | par_c;
`else
   assign any_err   = frame_c | seq_c | ovr_c;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         settle    <= 2'b00;
         armed     <= 1'b0;
         cnt       <= 4'd0;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
         par_bad   <= 1'b0;
         pending   <= 1'b0;
         hold      <= 7'd0;
         valid_q   <= 1'b0;
         data_q    <= 8'd0;
         addr_q    <= '0;
         frame_err <= 1'b0;
         seq_err   <= 1'b0;
         overrun   <= 1'b0;
         err_count <= '0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         // rx_s2 only reflects the pin two clocks after reset; arming waits for that
         settle  <= {settle[0], 1'b1};
         if (uart_clk) begin
            rx_prev <= rx_s2;
            if (settle[1] && rx_s2) armed <= 1'b1;
         end
         cnt       <= cnt_nx;
         bit_idx   <= bit_nx;
         shreg     <= sh_nx;
         par_bad   <= par_bad_nx;
         frame_err <= frame_c;
         seq_err   <= seq_c;
         overrun   <= ovr_c;
         if (byte_ok) begin
            if (!shreg[7]) begin
               hold    <= shreg[6:0];
               pending <= 1'b1;
            end else begin
               pending <= 1'b0;
            end
         end
         if (load) begin
            addr_q  <= shreg[ADDR_W:1];
            data_q  <= {shreg[0], hold};
            valid_q <= 1'b1;
         end else if (valid_q && bus.uart_ack) begin
            valid_q <= 1'b0;
         end
         if (any_err && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= par_c;
   end
`else
   assign parity_err = 1'b0;
`endif

   assign bus.uart_valid = valid_q;
   assign bus.uart_data  = data_q;
   assign bus.uart_addr  = addr_q;
endmodule

// File: tb/tb_uart_reg_rx.sv
// tb/tb_uart_reg_rx.sv - scoreboard bench for uart_reg_rx (BAUD_DIV=6, ADDR_W=4, ERR_CNT_W=8)
module tb_uart_reg_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_clk = 1'b0;
   logic       rx = 1'b1;
   logic       frame_err, seq_err, overrun, parity_err;
   logic [7:0] err_count;

   uart_reg_rx_if #(.ADDR_W(4)) bus ();

   uart_reg_rx #(.BAUD_DIV(6), .ADDR_W(4), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .uart_clk(uart_clk), .rx(rx), .bus(bus),
      .frame_err(frame_err), .seq_err(seq_err), .overrun(overrun),
      .parity_err(parity_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int tick_div = 1;
   int tph = 0;
   always @(negedge clk) begin
      tph = (tph + 1 >= tick_div) ? 0 : tph + 1;
      uart_clk = (tph == 0);
   end

   int total = 0;
   int bad = 0;
   int n_frame = 0, n_seq = 0, n_ovr = 0, n_par = 0, n_long = 0;
   logic p_frame = 0, p_seq = 0, p_ovr = 0, p_par = 0;
   always @(negedge clk) begin
      if (frame_err === 1'b1) n_frame++;
      if (seq_err === 1'b1) n_seq++;
      if (overrun === 1'b1) n_ovr++;
      if (parity_err === 1'b1) n_par++;
      if ((frame_err && p_frame) || (seq_err && p_seq) || (overrun && p_ovr) || (parity_err && p_par))
         n_long++;
      p_frame = frame_err; p_seq = seq_err; p_ovr = overrun; p_par = parity_err;
   end

   typedef struct packed { logic [3:0] addr; logic [7:0] data; } word_t;
   word_t      exp_q[$];
   word_t      w;
   logic       m_pending = 1'b0;
   logic [6:0] m_hold = 7'd0;

   task automatic model_byte(input logic [7:0] b);
      if (!b[7]) begin
         m_hold = b[6:0];
         m_pending = 1'b1;
      end else if (m_pending) begin
         exp_q.push_back({b[4:1], b[0], m_hold});
         m_pending = 1'b0;
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (uart_clk !== 1'b1) @(posedge clk);
      end
   endtask

   // Called at a negedge; returns at the negedge just before the stop-bit sample when tick_div=1
   task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_good);
      logic [10:0] bits;
      int n;
`ifdef UART_RX_PARITY_EN
      bits = {stop_v, (^b) ^ ~par_good, b, 1'b0};
      n = 11;
`else
      bits = {par_good, stop_v, b, 1'b0};
      n = 10;
`endif
      for (int i = 0; i < n; i++) begin
         rx = bits[i];
         wait_ticks(6);
         @(negedge clk);
      end
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         if (bus.uart_valid === 1'b1) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_ack();
      bus.uart_ack = 1'b1;
      @(negedge clk);
      bus.uart_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; rx = 1'b1; bus.uart_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_pending = 1'b0;
      exp_q.delete();
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; rx = 1'b1; bus.uart_ack = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.uart_valid, bus.uart_data, bus.uart_addr, frame_err, seq_err, overrun, parity_err, err_count} !== 25'd0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b data=%h addr=%h errs=%b%b%b%b cnt=%0d want all 0",
                  bus.uart_valid, bus.uart_data, bus.uart_addr, frame_err, seq_err, overrun, parity_err, err_count);
      end
      rst_n = 1'b1;
      m_pending = 1'b0;
      exp_q.delete();
      repeat (10) @(negedge clk);
      total++;
      if (bus.uart_valid !== 1'b0 || err_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_idle: got valid=%b cnt=%0d want 0/0", bus.uart_valid, err_count);
      end
   endtask

   task automatic test_word();
      do_reset();
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      total++;
      if (bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL word_early: valid=%b before stop sample, want 0", bus.uart_valid);
      end
      @(negedge clk);
      total++;
      if (bus.uart_valid !== 1'b1) begin
         bad++;
         $display("FAIL word_latency: valid=%b at T+1, want 1", bus.uart_valid);
      end
      w = exp_q.pop_front();
      total++;
      if (bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
         bad++;
         $display("FAIL word_value: got %h/%h want %h/%h", bus.uart_data, bus.uart_addr, w.data, w.addr);
      end
      do_ack();
      total++;
      if (bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL word_ack: valid=%b after ack, want 0", bus.uart_valid);
      end
   endtask

   task automatic test_seq();
      int s0;
      bit ok;
      do_reset();
      s0 = n_seq;
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (n_seq - s0 != 1 || err_count !== 8'd1 || bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL seq_err: got pulses=%0d cnt=%0d valid=%b want 1/1/0", n_seq - s0, err_count, bus.uart_valid);
      end
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      wait_valid(20, ok);
      w = exp_q.pop_front();
      total++;
      if (!ok || bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
         bad++;
         $display("FAIL seq_recover: got ok=%0d %h/%h want 1 %h/%h", ok, bus.uart_data, bus.uart_addr, w.data, w.addr);
      end
      do_ack();
   endtask

   task automatic test_overrun();
      int o0;
      bit ok;
      do_reset();
      o0 = n_ovr;
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      model_byte(8'h12); send_byte(8'h12, 1'b1, 1'b1);
      model_byte(8'h81); send_byte(8'h81, 1'b1, 1'b1);
      void'(exp_q.pop_back());
      repeat (4) @(negedge clk);
      w = exp_q.pop_front();
      total++;
      if (n_ovr - o0 != 1 || err_count !== 8'd1 || bus.uart_valid !== 1'b1 ||
          bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
         bad++;
         $display("FAIL overrun_hold: got pulses=%0d cnt=%0d valid=%b %h/%h want 1/1/1 %h/%h",
                  n_ovr - o0, err_count, bus.uart_valid, bus.uart_data, bus.uart_addr, w.data, w.addr);
      end
      do_ack();
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      wait_valid(20, ok);
      w = exp_q.pop_front();
      total++;
      if (!ok || bus.uart_data !== w.data) begin
         bad++;
         $display("FAIL overrun_first: got ok=%0d data=%h want 1 %h", ok, bus.uart_data, w.data);
      end
      model_byte(8'h12); send_byte(8'h12, 1'b1, 1'b1);
      model_byte(8'h81); send_byte(8'h81, 1'b1, 1'b1);
      do_ack();
      w = exp_q.pop_front();
      total++;
      if (bus.uart_valid !== 1'b1 || bus.uart_data !== w.data || bus.uart_addr !== w.addr || n_ovr - o0 != 1) begin
         bad++;
         $display("FAIL ack_on_complete: got valid=%b %h/%h ovr=%0d want 1 %h/%h ovr=1",
                  bus.uart_valid, bus.uart_data, bus.uart_addr, n_ovr - o0, w.data, w.addr);
      end
      do_ack();
   endtask

   task automatic test_break();
      int f0;
      bit ok;
      do_reset();
      f0 = n_frame;
      send_byte(8'h35, 1'b0, 1'b1);
      repeat (30) @(negedge clk);
      total++;
      if (n_frame - f0 != 1 || err_count !== 8'd1 || bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL frame_err: got pulses=%0d cnt=%0d valid=%b want 1/1/0", n_frame - f0, err_count, bus.uart_valid);
      end
      rx = 1'b1;
      repeat (5) @(negedge clk);
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      wait_valid(20, ok);
      w = exp_q.pop_front();
      total++;
      if (!ok || bus.uart_data !== w.data || bus.uart_addr !== w.addr || n_frame - f0 != 1) begin
         bad++;
         $display("FAIL break_recover: got ok=%0d %h/%h frames=%0d want 1 %h/%h 1",
                  ok, bus.uart_data, bus.uart_addr, n_frame - f0, w.data, w.addr);
      end
      do_ack();
   endtask

   task automatic test_glitch_and_rearm();
      bit ok;
      do_reset();
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (80) @(negedge clk);
      total++;
      if (err_count !== 8'd0 || bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL glitch: got cnt=%0d valid=%b want 0/0", err_count, bus.uart_valid);
      end
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_pending = 1'b0;
      repeat (90) @(negedge clk);
      total++;
      if (err_count !== 8'd0 || bus.uart_valid !== 1'b0) begin
         bad++;
         $display("FAIL rearm: got cnt=%0d valid=%b want 0/0 while rx held low", err_count, bus.uart_valid);
      end
      rx = 1'b1;
      repeat (5) @(negedge clk);
      model_byte(8'h35); send_byte(8'h35, 1'b1, 1'b1);
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      wait_valid(20, ok);
      w = exp_q.pop_front();
      total++;
      if (!ok || bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
         bad++;
         $display("FAIL rearm_word: got ok=%0d %h/%h want 1 %h/%h", ok, bus.uart_data, bus.uart_addr, w.data, w.addr);
      end
      do_ack();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq_b [4];
      seq_b[0] = 8'h7F; seq_b[1] = 8'hBF; seq_b[2] = 8'h00; seq_b[3] = 8'h80;
      tick_div = 3;
      do_reset();
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               model_byte(seq_b[i]);
               send_byte(seq_b[i], 1'b1, 1'b1);
            end
         end
         begin
            for (int k = 0; k < 2; k++) begin
               bit ok;
               wait_valid(3000, ok);
               w = exp_q.pop_front();
               total++;
               if (!ok || bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
                  bad++;
                  $display("FAIL b2b_word%0d: got ok=%0d %h/%h want 1 %h/%h", k, ok, bus.uart_data, bus.uart_addr, w.data, w.addr);
               end
               do_ack();
            end
         end
      join
      total++;
      if (err_count !== 8'd0) begin
         bad++;
         $display("FAIL b2b_errors: got cnt=%0d want 0", err_count);
      end
      tick_div = 1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int p0;
      bit ok;
      do_reset();
      p0 = n_par;
      model_byte(8'h22); send_byte(8'h22, 1'b1, 1'b1);
      send_byte(8'h35, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      total++;
      if (n_par - p0 != 1 || err_count !== 8'd1) begin
         bad++;
         $display("FAIL parity_err: got pulses=%0d cnt=%0d want 1/1", n_par - p0, err_count);
      end
      model_byte(8'h8B); send_byte(8'h8B, 1'b1, 1'b1);
      wait_valid(20, ok);
      w = exp_q.pop_front();
      total++;
      if (!ok || bus.uart_data !== w.data || bus.uart_addr !== w.addr) begin
         bad++;
         $display("FAIL parity_pending: got ok=%0d %h/%h want 1 %h/%h", ok, bus.uart_data, bus.uart_addr, w.data, w.addr);
      end
      do_ack();
   endtask
`endif

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 254; i++) send_byte(8'h8B, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (err_count !== 8'hFE) begin
         bad++;
         $display("FAIL err_count_254: got %h want fe", err_count);
      end
      for (int i = 0; i < 46; i++) send_byte(8'h8B, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      total++;
      if (err_count !== 8'hFF) begin
         bad++;
         $display("FAIL err_count_sat: got %h want ff", err_count);
      end
      total++;
      if (n_long != 0) begin
         bad++;
         $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", n_long);
      end
   endtask

   initial begin
      bus.uart_ack = 1'b0;
      test_reset();
      test_word();
      test_seq();
      test_overrun();
      test_break();
      test_glitch_and_rearm();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
